// File: rtl/tff_bank_arbiter_if.sv
// Bus bundle for tff_bank_arbiter: requests, toggle masks, clear, grant and bank state.
// The lock vector exists only when TFF_ARB_LOCK_EN is defined.
interface tff_bank_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] mask;
  logic           clr;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [W-1:0]   qbar;
  logic           busy;
`ifdef TFF_ARB_LOCK_EN
  logic [N-1:0]   lock;

  modport master (
    output req, mask, clr, lock,
    input  gnt, q, qbar, busy
  );
  modport slave (
    input  req, mask, clr, lock,
    output gnt, q, qbar, busy
  );
`else
  modport master (
    output req, mask, clr,
    input  gnt, q, qbar, busy
  );
  modport slave (
    input  req, mask, clr,
    output gnt, q, qbar, busy
  );
`endif
endinterface

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit T flip-flop bank between N requesters.
// Define TFF_ARB_LOCK_EN to add per-requester lock (winner keeps the bank while locked).
module tff_bank_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic               clk,
  input logic               rst,
  tff_bank_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(N);
  typedef logic [PtrW-1:0] idx_t;

`ifdef TFF_ARB_LOCK_EN
  typedef enum logic [1:0] {StIdle, StGrant, StLock} state_e;
`else
  typedef enum logic [1:0] {StIdle, StGrant} state_e;
`endif

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   q_q, q_d;
  idx_t           ptr_q, ptr_d;
  logic [W-1:0]   mask_arr [N];
  logic [N-1:0]   elig;
  logic           found;
  idx_t           win;
  idx_t           win_next;
`ifdef TFF_ARB_LOCK_EN
  idx_t           lock_w_q, lock_w_d;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      mask_arr[i] = bus.mask[i*W +: W];
    end
  end

  // Last cycle's winner sits out one cycle so a held req toggles once per gnt pulse.
  assign elig = bus.req & ~gnt_q;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && elig[idx_t'((ptr_q + k) % N)]) begin
        found = 1'b1;
        win   = idx_t'((ptr_q + k) % N);
      end
    end
    win_next = (win == idx_t'(N - 1)) ? '0 : win + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    q_d     = q_q;
    ptr_d   = ptr_q;
`ifdef TFF_ARB_LOCK_EN
    lock_w_d = lock_w_q;
`endif
    if (bus.clr) begin
      q_d     = '0;
      state_d = StIdle;
    end
`ifdef TFF_ARB_LOCK_EN
    else if (state_q == StLock) begin
      // ptr already points past the locked winner; leaving only drops the grant.
      if (bus.req[lock_w_q] && bus.lock[lock_w_q]) begin
        gnt_d = gnt_q;
        q_d   = q_q ^ mask_arr[lock_w_q];
      end else begin
        state_d = StIdle;
      end
    end
`endif
    else if (found) begin
      gnt_d   = N'(1) << win;
      q_d     = q_q ^ mask_arr[win];
      ptr_d   = win_next;
      state_d = StGrant;
`ifdef TFF_ARB_LOCK_EN
      lock_w_d = win;
      if (bus.lock[win]) state_d = StLock;
`endif
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      q_q     <= '0;
      ptr_q   <= '0;
`ifdef TFF_ARB_LOCK_EN
      lock_w_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      ptr_q   <= ptr_d;
`ifdef TFF_ARB_LOCK_EN
      lock_w_q <= lock_w_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.busy = (state_q != StIdle);

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Self-checking bench for tff_bank_arbiter: directed spec scenarios plus random traffic
// compared against a behavioural model of the round-robin toggle rules.
module tb_tff_bank_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b0;

  tff_bank_arbiter_if #(.N(N), .W(W)) bus ();

  tff_bank_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m [N];
  int mq;
  int mptr;
  int mlast;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] eg;
    eg = (mlast < 0) ? 32'd0 : (32'd1 << mlast);
    check({tag, ".gnt"},  32'(bus.gnt),  eg);
    check({tag, ".q"},    32'(bus.q),    32'(mq) & 32'hFF);
    check({tag, ".qbar"}, 32'(bus.qbar), ~32'(mq) & 32'hFF);
    check({tag, ".busy"}, 32'(bus.busy), (mlast < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic model_reset();
    mq    = 0;
    mptr  = 0;
    mlast = -1;
  endtask

  // One posedge of the spec rules: clr clears, else first eligible from ptr wins.
  task automatic model_step();
    int win;
    int r;
    win = -1;
    r   = int'(bus.req);
    if (bus.clr) begin
      mq    = 0;
      mlast = -1;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        int i;
        i = (mptr + k) % int'(N);
        if (win < 0 && ((r >> i) & 1) == 1 && i != mlast) win = i;
      end
      if (win >= 0) begin
        mq   = mq ^ int'(m[PW'(win)]);
        mptr = (win + 1) % int'(N);
      end
      mlast = win;
    end
  endtask

  task automatic drive_masks();
    for (int i = 0; i < int'(N); i++) bus.mask[i*W +: W] = m[i];
  endtask

  task automatic step(input string tag);
    drive_masks();
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Pulses rst between clock edges so the clear must be asynchronous.
  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

`ifdef TFF_ARB_LOCK_EN
  initial bus.lock = '0;
`endif

  logic [7:0] exp_g [5];
  logic [7:0] exp_q [5];

  initial begin
    bus.req = '0;
    bus.clr = 1'b0;
    for (int i = 0; i < int'(N); i++) m[i] = '0;
    drive_masks();
    model_reset();

    #2 rst = 1'b1;
    #1 check_all("reset");
    #5 rst = 1'b0;

    // Single held requester: one toggle per gnt pulse.
    m[0] = 8'h0F;
    bus.req = 4'b0001;
    for (int c = 0; c < 4; c++) step("single");
    check("single.q_final", 32'(bus.q), 32'h00);

    // All requesters held from a fresh pointer.
    async_reset("rst_mid");
    m[0] = 8'h01; m[1] = 8'h02; m[2] = 8'h04; m[3] = 8'h08;
    bus.req = 4'b1111;
    exp_g = '{8'h1, 8'h2, 8'h4, 8'h8, 8'h1};
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    for (int c = 0; c < 5; c++) begin
      step("rr");
      check("rr.gnt_const", 32'(bus.gnt), 32'(exp_g[c]));
      check("rr.q_const",   32'(bus.q),   32'(exp_q[c]));
    end

    // Async reset while a burst is running.
    async_reset("rst_burst");

    // clr beats a simultaneous request, which then wins next cycle.
    m[0] = 8'h5A; bus.req = 4'b0001;
    step("load5a");
    bus.req = 4'b0000;
    step("idle");
    check("load5a.q", 32'(bus.q), 32'h5A);
    m[1] = 8'h33; bus.req = 4'b0010; bus.clr = 1'b1;
    step("clr");
    check("clr.gnt", 32'(bus.gnt), 32'h0);
    bus.clr = 1'b0;
    step("after_clr");
    check("after_clr.gnt", 32'(bus.gnt), 32'h2);

    // Zero mask granted: gnt pulses, q holds.
    m[3] = 8'h00; bus.req = 4'b1000;
    step("zero_mask");

    // Random traffic with occasional clr and async reset.
    for (int c = 0; c < 400; c++) begin
      bus.req = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < int'(N); i++) m[i] = W'($urandom);
      bus.clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
      step("rand");
    end
    bus.clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
